gng_rom_arbiter: RTL and testbench
==================================

// Module: gng_rom_arbiter
// PURPOSE
// Shares the single game ROM memory port between the ROM download stream and four read clients:
// main CPU, sound CPU, char fetch and object fetch. It packs download bytes into 16-bit words and
// writes them, with priority over reads. Outside downloads it serves reads round-robin, one at a time.
// It sits between hps_io/jtgng_game ROM clients and the memory controller.
// PARAMETERS
// AW     22   word address width of memory port and of each client address
// DW     16   memory data width; download packs DW/8 = 2 bytes per word (only 16 supported)
// PORTS
// clk          in   1      system clock (clk_sys domain)
// rst_n        in   1      asynchronous, active-low reset
// downloading  in   1      ROM download in progress (ioctl_download)
// dl_wr        in   1      one-cycle byte strobe
// dl_addr      in   25     byte address of dl_data
// dl_data      in   8      download byte
// req          in   4      read request per client [0]=main [1]=sound [2]=char [3]=obj; level, held until data_ok
// addr         in   4*AW   client word addresses, client i at [i*AW +: AW]
// data_ok      out  4      one-cycle pulse to the served client: rd_data valid
// rd_data      out  DW     last read word, held until next read completes
// mem_req      out  1      memory request, held until mem_done
// mem_we       out  1      1=write, 0=read; stable while mem_req
// mem_addr     out  AW     memory word address; stable while mem_req
// mem_din      out  DW     write data; stable while mem_req
// mem_dout     in   DW     read data, valid with mem_done
// mem_done     in   1      one-cycle completion pulse
// dl_overflow  out  1      sticky: packed word lost because a write was still pending
// BEHAVIOUR
// - Reset: all outputs 0. FSM=IDLE, rr pointer=0, pack buffer empty, write-pending clear.
//   Asserting rst_n low mid-transaction drops mem_req at once. No data_ok is produced for it.
// - Packing: dl_wr with dl_addr[0]=0 stores the low byte. dl_wr with dl_addr[0]=1 forms the word
//   {dl_data, low} at word address dl_addr[AW:1] and sets write-pending.
// - Flush: on the falling edge of downloading with a low byte stored, queue {8'h00, low}.
// - Overflow: a word formed while write-pending is still set is dropped and dl_overflow sets.
//   dl_overflow clears only on reset or on the rising edge of downloading.
// - FSM IDLE:
//   - If write-pending: next cycle mem_req=1, mem_we=1, state WRITE.
//   - Else if ~downloading and |req: grant the first requesting client at or after rr.
//     Next cycle mem_req=1, mem_we=0, mem_addr=addr[g], state READ. Then rr <= g+1 mod 4.
//   - Write wins over reads when both are present in the same cycle.
// - FSM WRITE: on mem_done, mem_req=0 in the next cycle, write-pending clears, return to IDLE.
// - FSM READ: on mem_done, register rd_data=mem_dout, pulse data_ok[g] next cycle, mem_req=0,
//   return to IDLE.
//   - data_ok pulses even if req[g] dropped mid-flight; the client ignores it.
//   - A READ begun before downloading rises still completes.
// - mem_req deasserts for at least one cycle between transactions (IDLE cycle).
// - Latency: req high in IDLE at cycle t -> mem_req at t+1; mem_done at t+k -> data_ok at t+k+1.
// - Fairness: with all four requesting, grants go 0,1,2,3,0...; no client waits more than 3 reads.
// - mem_done outside READ/WRITE is ignored. addr is sampled only at grant.
// TESTING
// - Reset: rst_n=0 with req=4'hF -> all outputs 0. Release -> first grant is client 0.
// - Pack: bytes 0x10,0x83 at byte addr 0,1 -> mem_we=1, mem_addr=0, mem_din=16'h8310.
//   Done after 3 cycles -> back to IDLE.
// - Flush: 3-byte download 0xAA,0xBB,0xCC then downloading falls -> second write at addr 1,
//   data 16'h00CC.
// - Round robin: req=4'hF held, mem_done 2 cycles after each mem_req -> data_ok sequence 1,2,4,8,1.
//   Each rd_data equals mem_dout.
// - Priority/overflow: word ready with req=4'h2 -> write served first, read waits until
//   ~downloading. A second word formed before mem_done -> dl_overflow=1, only one write issued.
// - Abort: rst_n low during READ before mem_done -> mem_req=0 immediately, no data_ok.

Source files
------------

// File: rtl/gng_rom_arbiter_if.sv
// Memory-controller side of the ROM arbiter: one request/done handshake shared by writes and reads.
// The arbiter drives the request fields (master); the memory controller answers (slave).
interface gng_rom_arbiter_if #(
    parameter int unsigned AW = 22,
    parameter int unsigned DW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          done;

    modport master (
        output req,
        output we,
        output addr,
        output din,
        input  dout,
        input  done
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  din,
        output dout,
        output done
    );
endinterface

// File: rtl/gng_rom_arbiter.sv
// Shares one ROM memory port between the byte download stream (packed into 16-bit words, written
// with priority) and four round-robin read clients: main CPU, sound CPU, char and object fetch.
module gng_rom_arbiter #(
    parameter int unsigned AW = 22,
    parameter int unsigned DW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              downloading_i,
    input  logic              dl_wr_i,
    input  logic [24:0]       dl_addr_i,
    input  logic [7:0]        dl_data_i,
    input  logic [3:0]        req_i,
    input  logic [4*AW-1:0]   addr_i,
    output logic [3:0]        data_ok_o,
    output logic [DW-1:0]     rd_data_o,
    output logic              dl_overflow_o,
    gng_rom_arbiter_if.master mem
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e        state_q, state_d;
    logic [1:0]    rr_q, rr_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic [3:0]    data_ok_q, data_ok_d;
    logic [7:0]    low_q, low_d;
    logic          low_vld_q, low_vld_d;
    logic [AW-1:0] low_addr_q, low_addr_d;
    logic          wr_pend_q, wr_pend_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          ovf_q, ovf_d;
    logic          dl_q;

    logic          dl_rise, dl_fall, wr_done;
    logic          word_vld;
    logic [AW-1:0] word_addr;
    logic [DW-1:0] word_data;
    logic          gnt_found;
    logic [1:0]    gnt_idx;
    logic          unused_dl_addr;

    assign dl_rise        = downloading_i & ~dl_q;
    assign dl_fall        = ~downloading_i & dl_q;
    assign wr_done        = (state_q == StWrite) & mem.done;
    assign unused_dl_addr = ^dl_addr_i[24:AW+1];

    // Scan downwards so the closest requester at or after rr_q is the one left standing.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req_i[rr_q + 2'(k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_q + 2'(k);
            end
        end
    end

    always_comb begin
        low_d      = low_q;
        low_vld_d  = low_vld_q;
        low_addr_d = low_addr_q;
        wr_pend_d  = wr_pend_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        ovf_d      = ovf_q;
        word_vld   = 1'b0;
        word_addr  = low_addr_q;
        word_data  = DW'({8'h00, low_q});
        if (dl_wr_i) begin
            if (!dl_addr_i[0]) begin
                low_d      = dl_data_i;
                low_vld_d  = 1'b1;
                low_addr_d = dl_addr_i[AW:1];
            end else begin
                word_vld  = 1'b1;
                word_addr = dl_addr_i[AW:1];
                word_data = DW'({dl_data_i, low_q});
                low_vld_d = 1'b0;
            end
        end else if (dl_fall && low_vld_q) begin
            word_vld  = 1'b1;
            low_vld_d = 1'b0;
        end
        if (dl_rise) ovf_d = 1'b0;
        if (wr_done) wr_pend_d = 1'b0;
        // A pending word still owns the write buffer; the newcomer is lost.
        if (word_vld) begin
            if (wr_pend_q) begin
                ovf_d = 1'b1;
            end else begin
                wr_pend_d = 1'b1;
                wr_addr_d = word_addr;
                wr_data_d = word_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        rd_data_d  = rd_data_q;
        data_ok_d  = 4'b0000;
        unique case (state_q)
            StIdle: begin
                if (wr_pend_q) begin
                    state_d    = StWrite;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = wr_addr_q;
                    mem_din_d  = wr_data_q;
                end else if (!downloading_i && gnt_found) begin
                    state_d    = StRead;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_i[gnt_idx*AW +: AW];
                    gnt_d      = gnt_idx;
                    rr_d       = gnt_idx + 2'd1;
                end
            end
            StWrite: begin
                if (mem.done) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                end
            end
            StRead: begin
                if (mem.done) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    rd_data_d = mem.dout;
                    data_ok_d = 4'b0001 << gnt_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_q       <= 2'd0;
            gnt_q      <= 2'd0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rd_data_q  <= '0;
            data_ok_q  <= 4'b0000;
            low_q      <= 8'h00;
            low_vld_q  <= 1'b0;
            low_addr_q <= '0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ovf_q      <= 1'b0;
            dl_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rd_data_q  <= rd_data_d;
            data_ok_q  <= data_ok_d;
            low_q      <= low_d;
            low_vld_q  <= low_vld_d;
            low_addr_q <= low_addr_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            ovf_q      <= ovf_d;
            dl_q       <= downloading_i;
        end
    end

    assign mem.req       = mem_req_q;
    assign mem.we        = mem_we_q;
    assign mem.addr      = mem_addr_q;
    assign mem.din       = mem_din_q;
    assign data_ok_o     = data_ok_q;
    assign rd_data_o     = rd_data_q;
    assign dl_overflow_o = ovf_q;

endmodule

// File: tb/tb_gng_rom_arbiter.sv
// Self-checking bench for gng_rom_arbiter: the bench plays the memory controller and predicts
// grants, write words and read data from a small round-robin/packing model.
module tb_gng_rom_arbiter;
    localparam int AW = 22;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            downloading;
    logic            dl_wr;
    logic [24:0]     dl_addr;
    logic [7:0]      dl_data;
    logic [3:0]      req;
    logic [4*AW-1:0] addr;
    logic [3:0]      data_ok;
    logic [DW-1:0]   rd_data;
    logic            dl_overflow;
    logic [DW-1:0]   mem_dout;
    logic            mem_done;

    int n_checks = 0;
    int n_fail   = 0;
    int rr_m     = 0;

    gng_rom_arbiter_if #(.AW(AW), .DW(DW)) mem_if ();

    assign mem_if.dout = mem_dout;
    assign mem_if.done = mem_done;

    gng_rom_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .downloading_i (downloading),
        .dl_wr_i       (dl_wr),
        .dl_addr_i     (dl_addr),
        .dl_data_i     (dl_data),
        .req_i         (req),
        .addr_i        (addr),
        .data_ok_o     (data_ok),
        .rd_data_o     (rd_data),
        .dl_overflow_o (dl_overflow),
        .mem           (mem_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: first requester at or after the round-robin pointer.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    task automatic rand_addr();
        for (int i = 0; i < 4; i++) addr[i*AW +: AW] = AW'($urandom);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        downloading = 1'b0;
        dl_wr       = 1'b0;
        dl_addr     = '0;
        dl_data     = '0;
        req         = 4'h0;
        mem_dout    = '0;
        mem_done    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        rr_m  = 0;
        tick();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_if.req === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        tick();
        dl_wr = 1'b0;
    endtask

    task automatic serve_read(input int lat, input string tag);
        bit            ok;
        int            g;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] dout;
        g        = pick(req, rr_m);
        exp_addr = addr[g*AW +: AW];
        wait_req(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s read mem_req timeout got 0 want 1", tag);
            return;
        end
        n_checks++;
        if (mem_if.we !== 1'b0) begin
            n_fail++; $display("FAIL %s mem_we got %0b want 0", tag, mem_if.we);
        end
        n_checks++;
        if (mem_if.addr !== exp_addr) begin
            n_fail++; $display("FAIL %s mem_addr got %h want %h", tag, mem_if.addr, exp_addr);
        end
        rr_m = (g + 1) % 4;
        rand_addr();
        for (int i = 1; i < lat; i++) tick();
        n_checks++;
        if (mem_if.addr !== exp_addr) begin
            n_fail++; $display("FAIL %s held mem_addr got %h want %h", tag, mem_if.addr, exp_addr);
        end
        dout     = DW'($urandom);
        mem_dout = dout;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        mem_dout = DW'($urandom);
        n_checks++;
        if (mem_if.req !== 1'b0) begin
            n_fail++; $display("FAIL %s mem_req after done got %0b want 0", tag, mem_if.req);
        end
        n_checks++;
        if (data_ok !== 4'(1 << g)) begin
            n_fail++; $display("FAIL %s data_ok got %b want %b", tag, data_ok, 4'(1 << g));
        end
        n_checks++;
        if (rd_data !== dout) begin
            n_fail++; $display("FAIL %s rd_data got %h want %h", tag, rd_data, dout);
        end
    endtask

    task automatic serve_write(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input int lat,
                               input string tag);
        bit ok;
        wait_req(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s write mem_req timeout got 0 want 1", tag);
            return;
        end
        n_checks++;
        if (mem_if.we !== 1'b1) begin
            n_fail++; $display("FAIL %s mem_we got %0b want 1", tag, mem_if.we);
        end
        n_checks++;
        if (mem_if.addr !== wa) begin
            n_fail++; $display("FAIL %s mem_addr got %h want %h", tag, mem_if.addr, wa);
        end
        n_checks++;
        if (mem_if.din !== wd) begin
            n_fail++; $display("FAIL %s mem_din got %h want %h", tag, mem_if.din, wd);
        end
        for (int i = 1; i < lat; i++) tick();
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        n_checks++;
        if (mem_if.req !== 1'b0) begin
            n_fail++; $display("FAIL %s mem_req after done got %0b want 0", tag, mem_if.req);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        downloading = 1'b0;
        dl_wr       = 1'b0;
        dl_addr     = '0;
        dl_data     = '0;
        mem_done    = 1'b0;
        mem_dout    = '0;
        req         = 4'hF;
        rand_addr();
        tick();
        tick();
        n_checks++;
        if ({mem_if.req, mem_if.we, mem_if.addr, mem_if.din, data_ok, rd_data, dl_overflow} !== '0)
        begin
            n_fail++;
            $display("FAIL reset outputs got req=%0b we=%0b addr=%h din=%h ok=%b rd=%h ovf=%0b want 0",
                     mem_if.req, mem_if.we, mem_if.addr, mem_if.din, data_ok, rd_data, dl_overflow);
        end
        rst_n = 1'b1;
        rr_m  = 0;
        tick();
        n_checks++;
        if (mem_if.req !== 1'b1) begin
            n_fail++; $display("FAIL reset_latency mem_req got %0b want 1", mem_if.req);
        end
        serve_read(2, "reset_first_grant");
        req = 4'h0;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        rand_addr();
        req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            serve_read(2, "round_robin");
            tick();
            n_checks++;
            if (data_ok !== 4'h0) begin
                n_fail++; $display("FAIL rr_pulse data_ok got %b want 0000", data_ok);
            end
        end
        req = 4'h0;
        tick();
        tick();
    endtask

    task automatic test_random_reads();
        do_reset();
        for (int n = 0; n < 24; n++) begin
            req = 4'($urandom_range(1, 15));
            rand_addr();
            serve_read($urandom_range(1, 4), "random_read");
        end
        req = 4'h0;
        tick();
        tick();
    endtask

    task automatic test_pack();
        do_reset();
        downloading = 1'b1;
        tick();
        dl_byte(25'd0, 8'h10);
        dl_byte(25'd1, 8'h83);
        serve_write(22'd0, 16'h8310, 3, "pack");
        tick();
        n_checks++;
        if (mem_if.req !== 1'b0 || dl_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pack_idle req=%0b ovf=%0b want 0 0", mem_if.req, dl_overflow);
        end
        downloading = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        logic [AW-1:0] w;
        logic [7:0]    b0, b1, b2;
        do_reset();
        w  = AW'($urandom_range(0, 22'h3FFFFE));
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        downloading = 1'b1;
        tick();
        dl_byte({2'b00, w, 1'b0}, b0);
        dl_byte({2'b00, w, 1'b1}, b1);
        dl_byte({2'b00, w + 22'd1, 1'b0}, b2);
        serve_write(w, {b1, b0}, $urandom_range(1, 3), "flush_first");
        tick();
        downloading = 1'b0;
        serve_write(w + 22'd1, {8'h00, b2}, 2, "flush_tail");
        tick();
    endtask

    task automatic test_priority_overflow();
        bit ok;
        int extra;
        do_reset();
        downloading = 1'b1;
        tick();
        rand_addr();
        req = 4'h2;
        dl_byte(25'd0, 8'h34);
        dl_byte(25'd1, 8'h12);
        wait_req(ok);
        n_checks++;
        if (!ok || mem_if.we !== 1'b1 || mem_if.din !== 16'h1234) begin
            n_fail++;
            $display("FAIL prio_write ok=%0b we=%0b din=%h want 1 1 1234", ok, mem_if.we, mem_if.din);
        end
        dl_byte(25'd2, 8'h56);
        dl_byte(25'd3, 8'h78);
        n_checks++;
        if (dl_overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow_set got %0b want 1", dl_overflow);
        end
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_if.req === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++; $display("FAIL single_write extra mem_req cycles got %0d want 0", extra);
        end
        downloading = 1'b0;
        serve_read(2, "read_after_download");
        req = 4'h0;
        tick();
        n_checks++;
        if (dl_overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow_sticky got %0b want 1", dl_overflow);
        end
        downloading = 1'b1;
        tick();
        n_checks++;
        if (dl_overflow !== 1'b0) begin
            n_fail++; $display("FAIL overflow_clear got %0b want 0", dl_overflow);
        end
        downloading = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        bit ok;
        int bad_ok;
        do_reset();
        rand_addr();
        req = 4'h4;
        wait_req(ok);
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!ok || mem_if.req !== 1'b0 || data_ok !== 4'h0) begin
            n_fail++;
            $display("FAIL abort ok=%0b mem_req=%0b data_ok=%b want 1 0 0000", ok, mem_if.req, data_ok);
        end
        tick();
        rst_n  = 1'b1;
        rr_m   = 0;
        bad_ok = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (data_ok !== 4'h0) bad_ok++;
        end
        n_checks++;
        if (bad_ok !== 0) begin
            n_fail++; $display("FAIL abort_no_data_ok cycles got %0d want 0", bad_ok);
        end
        serve_read(1, "after_abort");
        req = 4'h0;
        tick();
    endtask

    task automatic test_stray_done();
        req      = 4'h0;
        tick();
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        n_checks++;
        if (mem_if.req !== 1'b0 || data_ok !== 4'h0) begin
            n_fail++;
            $display("FAIL stray_done mem_req=%0b data_ok=%b want 0 0000", mem_if.req, data_ok);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_random_reads();
        test_pack();
        test_flush();
        test_priority_overflow();
        test_abort();
        test_stray_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
